// File: rtl/sr_ff_bank.sv
// sr_ff_bank: multi-mode (SR/JK/D/T) flip-flop bank; SR_FF_INVALID_CNT_EN adds the err_cnt counter
module sr_ff_bank #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter int               INVALID_POLICY = 0,
  parameter int               CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] inv,
  output logic             err
`ifdef SR_FF_INVALID_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;
  logic [WIDTH-1:0] q_q, q_d, inv_q, inv_d;
  logic             err_q, err_d;
  // per-bit next state; S=R=1 means toggle in JK and policy-resolved invalid in SR
  always_comb begin
    q_d   = q_q;
    inv_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inv_d[i] = en && mode == M_SR && s[i] && r[i];
      q_d[i]   = !en ? q_q[i] :
                 mode == M_D ? s[i] :
                 mode == M_T ? q_q[i] ^ s[i] :
                 (s[i] && r[i]) ? (mode == M_JK ? ~q_q[i] :
                                   INVALID_POLICY == 1 ? 1'b0 :
                                   INVALID_POLICY == 2 ? 1'b1 : q_q[i]) :
                 s[i] ? 1'b1 : r[i] ? 1'b0 : q_q[i];
    end
  end
  // a new invalid event wins over a simultaneous clear
  assign err_d = |inv_d ? 1'b1 : clr_err ? 1'b0 : err_q;
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      inv_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      inv_q <= inv_d;
      err_q <= err_d;
    end
  end
`ifdef SR_FF_INVALID_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (|inv_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // saturating count of edges carrying at least one invalid bit; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign err_cnt = cnt_q;
`endif
  assign q   = q_q;
  assign qb  = ~q_q;
  assign inv = inv_q;
  assign err = err_q;
endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised multi-mode flip-flop bank; successor to the single-bit SR flip-flop. Holds WIDTH independent storage bits that share one clock, one synchronous reset, an enable and a runtime mode select (SR, JK, D, T). In SR mode it detects the forbidden S=R=1 input, resolves it with a configurable policy and reports it through per-bit flags and a sticky error bit. It sits in the sequential-primitives library as the generic latch-and-hold element for control registers.

## Interface
- WIDTH, 8, number of independent flip-flop bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- INVALID_POLICY, 0, SR-mode S=R=1 resolution: 0 = hold, 1 = force 0, 2 = force 1. Other values behave as 0.
- CNT_W, 8, width of the invalid-event counter (only with SR_FF_INVALID_CNT_EN).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  update enable; 0 = all bits hold.
- mode  in  2  00 SR, 01 JK, 10 D, 11 T; applies to all bits.
- s  in  WIDTH  set / J / D / T input per bit.
- r  in  WIDTH  reset / K input per bit; ignored in D and T modes.
- clr_err  in  1  clears the sticky err.
- q  out  WIDTH  stored state.
- qb  out  WIDTH  ~q, combinational from q.
- inv  out  WIDTH  registered one-cycle flag; bit i=1 if bit i saw S=R=1 in SR mode at the previous enabled edge.
- err  out  1  sticky: set by any invalid event.
- err_cnt  out  CNT_W  saturating count of edges with at least one invalid bit. Present only with the macro.

## Operation
- Reset (rst=1 at the edge) has priority over everything. q=RESET_VAL, qb=~RESET_VAL, inv=0, err=0, err_cnt=0.
- en=0 with rst=0: q holds, inv=0, and no events are detected. err and err_cnt hold, but clr_err still acts.
- en=1, per bit i, next q[i] by mode:
  - SR: 10→1, 01→0, 00→hold, 11→policy (hold/0/1) and inv[i]=1.
  - JK: 10→1, 01→0, 00→hold, 11→toggle. No invalid event.
  - D: q[i]=s[i].
  - T: s[i]=1→toggle, else hold.
- inv is cleared at every edge where its bit is not re-detected.
- err is set at any edge where |inv_next=1. Otherwise clr_err=1 clears it. A new event and clr_err at the same edge leave err=1.
- A mode change takes effect at the same edge it is sampled. No mode-transition state is kept.
- Bits are fully independent. Mixed set/reset/invalid across bits in one cycle is legal.

## Timing
- All inputs are sampled at the rising edge of clk. q, inv, err and err_cnt are valid after that edge, giving 1-cycle latency.
- qb has zero cycles of latency relative to q (combinational).
- No handshake. The block accepts new inputs every cycle.
- If rst is asserted mid-operation, state is discarded at that edge. The first functional edge is the first one with rst=0.
- err_cnt saturates at 2^CNT_W−1 and does not wrap. It clears only on rst; clr_err does not affect it.

## Configuration
- SR_FF_INVALID_CNT_EN defined: err_cnt port and counter exist. The counter increments by 1 per edge with |inv_next=1, regardless of how many bits are invalid.
- Not defined: err_cnt port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b1010, rst=1 for one edge → q=1010, qb=0101, inv=0, err=0, err_cnt=0.
- SR basics and invalid, with mode=00, en=1, INVALID_POLICY=0. Apply s=0011, r=1100 → q=0011. Then s=0001, r=0001 → q=0011, inv=0001, err=1, err_cnt=1. Next cycle with s=r=0 → inv=0000, err stays 1.
- Policies: q=0000, s=r=1111 → q=0000 under policy 1 and q=1111 under policy 2. inv=1111 in both cases, and err_cnt increments by exactly 1.
- JK, D and T modes: from q=0101, JK with s=r=1111 → q=1010 and inv=0. D with s=0110 → q=0110. T with s=0011 → q=0101.
- Enable and clr_err: en=0 with s=r=1111 in SR mode → q holds, inv=0. Then clr_err=1 with err=1 → err=0. Then clr_err=1 together with a new invalid → err=1.
- Saturation (macro defined, CNT_W=2): 5 consecutive invalid edges → err_cnt reads 1, 2, 3, 3, 3. Then rst → err_cnt=0.
